// File: rtl/prot_capture_ctrl_if.sv
// Capture-controller bus: host/config and trigger-unit inputs, sample-RAM
// write port and status outputs. The master side drives the controls and
// the slave side is the capture controller.
interface prot_capture_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              arm;
  logic              abort;
  logic              smpl_en;
  logic              protTrig;
  logic [ADDR_W-1:0] trig_pos;
  logic              clr_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              armed;
  logic              triggered;
  logic              capture_done;

  modport master (
    output arm, abort, smpl_en, protTrig, trig_pos, clr_done,
    input  we, waddr, trig_addr, armed, triggered, capture_done
  );

  modport slave (
    input  arm, abort, smpl_en, protTrig, trig_pos, clr_done,
    output we, waddr, trig_addr, armed, triggered, capture_done
  );
endinterface

// File: rtl/prot_capture_ctrl.sv
// Logic-analyzer capture sequencer. Arms on command, streams samples into a
// circular RAM, qualifies the protocol trigger, collects trig_pos
// post-trigger samples and then freezes the RAM with a sticky done flag.
// Optional macro TRIG_HOLDOFF_EN adds a PRE state that holds off triggers
// until the pre-trigger window (DEPTH - trig_pos samples) has been filled.
module prot_capture_ctrl #(
  parameter int DEPTH  = 384,
  parameter int ADDR_W = 9
) (
  input logic              clk,
  input logic              rst_n,
  prot_capture_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

`ifdef TRIG_HOLDOFF_EN
  localparam logic [2:0] ST_START = ST_PRE;
`else
  localparam logic [2:0] ST_START = ST_WAIT;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] waddr_next;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] tp_reg;
  logic [ADDR_W-1:0] tp_clamped;
  logic              triggered;
  logic              capturing;

  // Clamp the requested post-trigger count into the legal range 1..DEPTH-1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    tp_clamped = bus.trig_pos;
    if (bus.trig_pos == '0) begin
      tp_clamped = ADDR_W'(1);
    end else if ({1'b0, bus.trig_pos} >= (ADDR_W + 1)'(DEPTH)) begin
      tp_clamped = LAST_ADDR;
    end
  end

  assign waddr_next = (waddr == LAST_ADDR) ? '0 : waddr + ADDR_W'(1);
  assign capturing  = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);

`ifdef TRIG_HOLDOFF_EN
  // waddr counts writes since arm while in PRE (no wrap is possible there),
  // so the window is full once the write at this address has happened.
  logic [ADDR_W-1:0] pre_last;
  assign pre_last = ADDR_W'(DEPTH) - tp_reg - ADDR_W'(1);
`endif

  // Capture sequencing: abort > arm > per-state progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= ST_IDLE;
      waddr     <= '0;
      trig_addr <= '0;
      post_cnt  <= '0;
      tp_reg    <= ADDR_W'(1);
      triggered <= 1'b0;
    end else if (bus.abort) begin
      state     <= ST_IDLE;
      triggered <= 1'b0;
    end else if (bus.arm) begin
      state     <= ST_START;
      waddr     <= '0;
      post_cnt  <= '0;
      tp_reg    <= tp_clamped;
      triggered <= 1'b0;
    end else begin
      case (state)
`ifdef TRIG_HOLDOFF_EN
        ST_PRE: begin
          if (bus.smpl_en) begin
            waddr <= waddr_next;
            if (waddr == pre_last) state <= ST_WAIT;
          end
        end
`endif
        ST_WAIT: begin
          if (bus.smpl_en) begin
            waddr <= waddr_next;
            if (bus.protTrig) begin
              trig_addr <= waddr;
              triggered <= 1'b1;
              post_cnt  <= ADDR_W'(1);
              state     <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (bus.smpl_en) begin
            waddr <= waddr_next;
            if (post_cnt == tp_reg) state <= ST_DONE;
            else                    post_cnt <= post_cnt + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.clr_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.we           = capturing && bus.smpl_en;
  assign bus.waddr        = waddr;
  assign bus.trig_addr    = trig_addr;
  assign bus.armed        = (state == ST_PRE) || (state == ST_WAIT);
  assign bus.triggered    = triggered;
  assign bus.capture_done = (state == ST_DONE);

endmodule

// File: tb/tb_prot_capture_ctrl.sv
// Testbench for prot_capture_ctrl: a capture-level reference model checks
// every output on every cycle, a table of complete captures checks trigger
// address, post-trigger count and final address, hand sequences cover the
// abort / reset / arm+clr corner cases, then a randomized run follows.
`timescale 1ns/1ps
module tb_prot_capture_ctrl;
  localparam int DEPTH  = 384;
  localparam int ADDR_W = 9;
  localparam int BIG    = 1000000;

`ifdef TRIG_HOLDOFF_EN
  localparam bit HOLDOFF = 1'b1;
`else
  localparam bit HOLDOFF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prot_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  prot_capture_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: a capture is "running" from arm until the last
  // post-trigger sample; it counts total writes since arm.
  bit m_running, m_trig_seen, m_triggered, m_done;
  bit m_waddr_known, m_trig_known;
  int m_writes, m_post_left, m_tp, m_trig_addr;

  // Output values sampled during the most recent cycle.
  logic        s_we, s_armed, s_triggered, s_done;
  logic [31:0] s_waddr, s_trig_addr;

  // Results of the most recent run_capture call.
  int r_posts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_tp(input int tp);
    if (tp == 0) return 1;
    if (tp >= DEPTH) return DEPTH - 1;
    return tp;
  endfunction

  task automatic model_step(input bit rn, a, ab, s, t, c, input int tp);
    if (!rn) begin
      m_running = 0; m_trig_seen = 0; m_triggered = 0; m_done = 0;
      m_writes = 0; m_post_left = 0; m_trig_addr = 0;
      m_waddr_known = 1; m_trig_known = 1;
    end else if (ab) begin
      m_running = 0; m_trig_seen = 0; m_triggered = 0; m_done = 0;
      m_waddr_known = 0;
    end else if (a) begin
      m_running = 1; m_trig_seen = 0; m_triggered = 0; m_done = 0;
      m_writes = 0; m_tp = clamp_tp(tp); m_waddr_known = 1;
    end else if (m_running && s) begin
      if (!m_trig_seen) begin
        if (t && (!HOLDOFF || m_writes >= DEPTH - m_tp)) begin
          m_trig_addr = m_writes % DEPTH; m_trig_known = 1;
          m_trig_seen = 1; m_triggered = 1; m_post_left = m_tp;
        end
      end else begin
        m_post_left--;
        if (m_post_left == 0) begin
          m_running = 0; m_done = 1;
        end
      end
      m_writes++;
    end else if (m_done && c) begin
      m_done = 0; m_waddr_known = 0;
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, sample and compare
  // against the model, then advance the model to match the coming edge.
  task automatic cycle(input bit a, ab, s, t, c, input int tp, input bit rn = 1'b1);
    @(negedge clk);
    rst_n        = rn;
    bus.arm      = a;
    bus.abort    = ab;
    bus.smpl_en  = s;
    bus.protTrig = t;
    bus.clr_done = c;
    bus.trig_pos = ADDR_W'(tp);
    #1;
    s_we = bus.we; s_armed = bus.armed; s_triggered = bus.triggered;
    s_done = bus.capture_done; s_waddr = 32'(bus.waddr); s_trig_addr = 32'(bus.trig_addr);
    if (chk_en) begin
      check("we",           32'(s_we),        32'(m_running && s));
      check("armed",        32'(s_armed),     32'(m_running && !m_trig_seen));
      check("triggered",    32'(s_triggered), 32'(m_triggered));
      check("capture_done", 32'(s_done),      32'(m_done));
      if (m_waddr_known) check("waddr", s_waddr, 32'(m_writes % DEPTH));
      if (m_trig_known)  check("trig_addr", s_trig_addr, 32'(m_trig_addr));
    end
    model_step(rn, a, ab, s, t, c, tp);
  endtask

  // Arm with trig_pos=tp, stream one sample per cycle with protTrig high
  // while the write index is in [lo, hi], until capture_done is seen.
  // trig_pos is perturbed after arm to show it is only sampled on arm.
  task automatic run_capture(input int tp, input int lo, input int hi);
    int k = 0;
    int cyc = 0;
    r_posts = 0;
    cycle(1, 0, 0, 0, 0, tp);
    s_done = 1'b0;
    while (!s_done && cyc < 2500) begin
      cycle(0, 0, 1, (k >= lo && k <= hi), 0, tp ^ 7);
      if (s_we) begin
        if (s_triggered) r_posts++;
        k++;
      end
      cyc++;
    end
    check("done_reached", 32'(s_done), 32'd1);
  endtask

  typedef struct {
    int tp;
    int n;
    int exp_trig;
    int exp_final;
    int exp_posts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_tp = 50;

    // trig_pos, samples before protTrig rises (held), expected trig_addr,
    // expected frozen waddr, expected post-trigger writes.
    vecs[0] = '{tp: 100, n: 300, exp_trig: 300, exp_final:  17, exp_posts: 100};
    vecs[1] = '{tp:  10, n: 400, exp_trig:  16, exp_final:  27, exp_posts:  10};
    vecs[2] = '{tp:   0, n: 383, exp_trig: 383, exp_final:   1, exp_posts:   1};
    vecs[3] = '{tp: 500, n:   5, exp_trig:   5, exp_final:   5, exp_posts: 383};
    vecs[4] = '{tp: 383, n:   1, exp_trig:   1, exp_final:   1, exp_posts: 383};
    vecs[5] = '{tp:   1, n: 700, exp_trig: 316, exp_final: 318, exp_posts:   1};

    bus.arm = 0; bus.abort = 0; bus.smpl_en = 0; bus.protTrig = 0;
    bus.clr_done = 0; bus.trig_pos = '0;
    m_tp = 1;

    // Reset, then reset-value checks.
    cycle(0, 0, 0, 0, 0, 0, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, 1'b0);
    chk_en = 1'b1;
    cycle(0, 0, 1, 1, 0, 0);
    check("rst_we",        32'(s_we),        0);
    check("rst_armed",     32'(s_armed),     0);
    check("rst_triggered", 32'(s_triggered), 0);
    check("rst_done",      32'(s_done),      0);
    check("rst_waddr",     s_waddr,          0);
    check("rst_trig_addr", s_trig_addr,      0);

    // Table of complete captures.
    for (int i = 0; i < 6; i++) begin
      run_capture(vecs[i].tp, vecs[i].n, BIG);
      check("tbl_trig_addr", s_trig_addr, 32'(vecs[i].exp_trig));
      check("tbl_final_waddr", s_waddr, 32'(vecs[i].exp_final));
      check("tbl_posts", 32'(r_posts), 32'(vecs[i].exp_posts));
      cycle(0, 0, 1, 1, 0, 0);
      check("tbl_we_after_done", 32'(s_we), 0);
      check("tbl_waddr_frozen", s_waddr, 32'(vecs[i].exp_final));
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0);
      check("tbl_done_cleared", 32'(s_done), 0);
    end

`ifdef TRIG_HOLDOFF_EN
    // protTrig high from arm: held off until the pre window is full.
    run_capture(100, 0, BIG);
    check("holdoff_trig_addr", s_trig_addr, 32'd284);
    check("holdoff_final_waddr", s_waddr, 32'd1);
    check("holdoff_posts", 32'(r_posts), 32'd100);
`else
    // Single-cycle trigger pulse at the 10th sample.
    run_capture(100, 9, 9);
    check("c1_trig_addr", s_trig_addr, 32'd9);
    check("c1_final_waddr", s_waddr, 32'd110);
    check("c1_posts", 32'(r_posts), 32'd100);
`endif
    cycle(0, 0, 1, 0, 0, 0);
    check("c1_we_after_done", 32'(s_we), 0);

    // Sparse samples; trigger pulse on a cycle without a sample is ignored.
    cycle(1, 0, 0, 0, 0, 50);
    for (int c = 0; c < 40; c++) cycle(0, 0, (c % 4 == 0), (c == 6), 0, 50);
    check("c4_triggered", 32'(s_triggered), 0);
    check("c4_armed", 32'(s_armed), 1);
    cycle(0, 1, 0, 0, 0, 50);

    // Abort in POST.
    cycle(1, 0, 0, 0, 0, 20);
    for (int c = 0; c < 1000; c++) begin
      cycle(0, 0, 1, 1, 0, 20);
      if (s_triggered) break;
    end
    check("c5_in_post", 32'(s_triggered), 1);
    cycle(0, 0, 1, 0, 0, 20);
    cycle(0, 1, 1, 0, 0, 20);
    cycle(0, 0, 1, 0, 0, 20);
    check("c5_abort_armed", 32'(s_armed), 0);
    check("c5_abort_triggered", 32'(s_triggered), 0);
    check("c5_abort_done", 32'(s_done), 0);
    check("c5_abort_we", 32'(s_we), 0);
    // arm together with clr_done in DONE restarts.
    run_capture(5, 0, BIG);
    cycle(1, 0, 0, 0, 1, 5);
    cycle(0, 0, 0, 0, 0, 5);
    check("c5_restart_armed", 32'(s_armed), 1);
    check("c5_restart_done", 32'(s_done), 0);
    check("c5_restart_triggered", 32'(s_triggered), 0);
    check("c5_restart_waddr", s_waddr, 0);
    // clr_done outside DONE has no effect.
    cycle(0, 0, 1, 0, 1, 5);
    cycle(0, 0, 0, 0, 0, 5);
    check("c5_clr_in_wait_armed", 32'(s_armed), 1);
    check("c5_clr_in_wait_waddr", s_waddr, 1);

    // Reset mid-capture, then arm is needed to resume.
    cycle(1, 0, 0, 0, 0, 50);
    for (int c = 0; c < 5; c++) cycle(0, 0, 1, 0, 0, 50);
    cycle(0, 0, 1, 0, 0, 50, 1'b0);
    cycle(0, 0, 1, 1, 0, 50);
    check("c6_we", 32'(s_we), 0);
    check("c6_armed", 32'(s_armed), 0);
    check("c6_triggered", 32'(s_triggered), 0);
    check("c6_done", 32'(s_done), 0);
    check("c6_waddr", s_waddr, 0);
    check("c6_trig_addr", s_trig_addr, 0);
    for (int c = 0; c < 3; c++) cycle(0, 0, 1, 1, 0, 50);
    check("c6_idle_we", 32'(s_we), 0);
    cycle(1, 0, 0, 0, 0, 50);
    cycle(0, 0, 1, 0, 0, 50);
    check("c6_rearm_armed", 32'(s_armed), 1);
    check("c6_rearm_we", 32'(s_we), 1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 8000; c++) begin
      bit a, ab, s, t, cl, rn;
      int tp;
      s  = ($urandom_range(0, 1) == 1);
      t  = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 40) == 0);
      ab = ($urandom_range(0, 2999) == 0);
      rn = !($urandom_range(0, 3999) == 0);
      if (m_running || m_done) a = ($urandom_range(0, 899) == 0);
      else                     a = ($urandom_range(0, 9) == 0);
      if (a) cur_tp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40))
                                                  : int'($urandom_range(0, 511));
      tp = a ? cur_tp : int'($urandom_range(0, 511));
      cycle(a, ab, s, t, cl, tp, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prot_capture_ctrl.md
Name: prot_capture_ctrl

Overview:
- Sequences a logic-analyzer capture around the protocol trigger.
- Arms on command, writes samples into a circular sample RAM, and qualifies protTrig.
- After the trigger, counts trig_pos post-trigger samples, then freezes the RAM and reports done with a trigger address.
- Sits between the command/config logic and the protocol trigger unit plus sample RAM.

Parameters:
- DEPTH, 384, number of sample RAM entries.
- ADDR_W, 9, RAM address width; ceil(log2(DEPTH)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- arm  in  1  1-cycle pulse: start a new capture.
- abort  in  1  1-cycle pulse: return to IDLE, no done.
- smpl_en  in  1  sample strobe from decimator; one RAM write per strobe.
- protTrig  in  1  trigger from the protocol trigger unit (level).
- trig_pos  in  ADDR_W  post-trigger sample count; legal 1..DEPTH-1.
- clr_done  in  1  1-cycle pulse: host acknowledges capture_done.
- we  out  1  RAM write enable (= smpl_en in PRE/WAIT/POST).
- waddr  out  ADDR_W  RAM write address.
- trig_addr  out  ADDR_W  waddr value at the trigger sample.
- armed  out  1  high in PRE and WAIT.
- triggered  out  1  high from trigger until next arm/abort/reset.
- capture_done  out  1  sticky done flag.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, waddr=0, trig_addr=0, post counter=0. All of we, armed, triggered and capture_done are 0.
- States: IDLE, PRE, WAIT, POST, DONE.
- IDLE:
  - arm -> PRE next cycle.
  - On arm: waddr:=0, post_cnt:=0, triggered:=0, capture_done:=0.
- PRE:
  - Each smpl_en writes; waddr increments.
  - Go to WAIT when pre_cnt reaches DEPTH-trig_pos, i.e. the pre-trigger window is full.
  - Without TRIG_HOLDOFF_EN, PRE is skipped: arm goes directly to WAIT.
- WAIT:
  - Writes continue; waddr wraps DEPTH-1 -> 0.
  - The first cycle with protTrig=1 AND smpl_en=1 is the trigger sample:
    - trig_addr:=current waddr; triggered:=1; post_cnt:=1.
    - -> POST.
  - protTrig while smpl_en=0 is ignored (not latched).
- POST:
  - Each smpl_en writes and post_cnt increments.
  - When post_cnt==trig_pos and smpl_en: the final write occurs, then -> DONE.
  - Net result: exactly trig_pos samples after the trigger sample.
  - protTrig is ignored.
- DONE:
  - we=0; waddr frozen; capture_done=1.
  - capture_done is held until clr_done (-> IDLE, done cleared next cycle) or arm (restart, as from IDLE).
- Latency:
  - arm -> armed=1 on the next cycle.
  - The final post-trigger write -> capture_done=1 on the next cycle.
- we and waddr are registered-consistent: the write at edge N uses the waddr presented during cycle N. waddr increments after each write.
- Simultaneous events:
  - abort beats everything except reset; it goes to IDLE and leaves capture_done=0.
  - arm in PRE/WAIT/POST restarts the capture (counters cleared, triggered=0).
  - arm and clr_done together in DONE: arm wins.
  - clr_done outside DONE: no effect.
- trig_pos is sampled into an internal register on arm. Later changes have no effect until the next arm.
  - trig_pos=0 is treated as 1.
  - trig_pos>=DEPTH is clamped to DEPTH-1.
- Reset mid-capture returns everything to reset values. The RAM contents are undefined to the host.

Optional Feature:
- Macro TRIG_HOLDOFF_EN.
- Defined: the PRE state exists. Triggers are suppressed until DEPTH-trig_pos samples have been written since arm, so the pre-trigger history is always valid.
- Undefined: arm goes straight to WAIT. A trigger is accepted on the first qualifying sample, and pre-trigger history may be partially stale.

Test Plan:
- Case 1, no macro, DEPTH=384, trig_pos=100, smpl_en=1 continuously.
  - Stimulus: arm, protTrig pulsed at the 10th sample (waddr=9).
  - Required: trig_addr=9; 100 further writes; capture_done=1 with waddr=(9+101)%384=110; we=0 thereafter.
- Case 2, macro defined, trig_pos=100.
  - Stimulus: protTrig held high from arm.
  - Required: no trigger until 284 writes; trig_addr=284; done after 100 more writes.
- Case 3, wrap.
  - Stimulus: trig_pos=10, trigger after 400 samples.
  - Required: waddr wraps 383->0; trig_addr=400%384=16.
- Case 4, smpl_en=1 every 4th cycle.
  - Stimulus: protTrig pulsed on a cycle with smpl_en=0.
  - Required: the pulse is ignored; triggered stays 0.
- Case 5, abort in POST.
  - Required: armed=0, triggered=0, capture_done=0 next cycle.
  - Then arm in DONE together with clr_done: the capture restarts.
- Case 6, rst_n low mid-WAIT for 1 cycle.
  - Required: all outputs at reset values; arm is then required to resume capture.
